instr_fetch_queue: RTL and testbench

Instruction fetch stage placed directly upstream of the single-cycle RISC-V datapath's decode/register-file logic. It owns the fetch PC, issues one word read at a time to a variable-latency instruction memory, and buffers returned instructions with their PCs in a small FIFO. A valid/ready handshake presents the FIFO head to the consuming stage. A redirect input (branch/jump) flushes the queue and discards any in-flight response.

---
 rtl/instr_fetch_queue.sv | 226 ++++++++++++++++++++++
 tb/tb_instr_fetch_queue.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
//
// Fetch stage that sits in front of decode. It owns the fetch PC and keeps a
// single read request outstanding to a variable-latency instruction memory.
// Returned words are queued with their PCs in a DEPTH-entry FIFO, and the
// FIFO head is presented to the consumer. A redirect flushes the queue,
// reloads the fetch PC and discards any response still in flight.
//
// Parameters
//   DEPTH     FIFO entries; power of two, at least 2
//   RESET_PC  fetch PC loaded on reset
//
// Ports
//   clk_i          in   1   clock, rising edge
//   rst_i          in   1   synchronous active-high reset
//   imem_req_o     out  1   read request valid
//   imem_addr_o    out  32  request byte address (word aligned)
//   imem_gnt_i     in   1   memory accepts the request this cycle
//   imem_rvalid_i  in   1   read data valid (at least one cycle after grant)
//   imem_rdata_i   in   32  returned instruction word
//   instr_valid_o  out  1   FIFO head valid
//   instr_o        out  32  FIFO head instruction, 0 when empty
//   pc_o           out  32  FIFO head PC, 0 when empty
//   instr_ready_i  in   1   consumer takes the head this cycle
//   redirect_i     in   1   flush and restart fetch
//   redirect_pc_i  in   32  new fetch PC, bits [1:0] ignored
//
// Handshakes
//   Consumer side: a transfer happens in any cycle where instr_valid_o and
//   instr_ready_i are both high. While instr_valid_o is high and no transfer
//   or redirect occurs, instr_o/pc_o hold their values. instr_ready_i may be
//   asserted at any time; instr_valid_o never depends on instr_ready_i.
//   Memory side: a request is accepted in any cycle where imem_req_o and
//   imem_gnt_i are both high. imem_addr_o is stable while imem_req_o waits
//   for a grant, unless a redirect intervenes (which also drops imem_req_o
//   for that cycle). Exactly one response is expected per accepted request.
// -----------------------------------------------------------------------------
module instr_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("instr_fetch_queue: DEPTH must be a power of two and at least 2");
  end

  // IDLE: no request outstanding.
  // WAIT: one request granted, its response will be queued.
  // DROP: one request granted before a redirect, its response is discarded.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } state_e;

  state_e            state_q,    state_d;
  logic [31:0]       fetch_pc_q, fetch_pc_d;
  logic [31:0]       req_pc_q,   req_pc_d;
  logic [PTR_W-1:0]  rptr_q,     rptr_d;
  logic [PTR_W-1:0]  wptr_q,     wptr_d;
  logic [CNT_W-1:0]  count_q,    count_d;

  // FIFO storage; contents are qualified by count_q so no reset is needed.
  logic [31:0] fifo_pc_q    [DEPTH];
  logic [31:0] fifo_instr_q [DEPTH];

  logic not_full;
  logic fifo_empty;
  logic grant;
  logic push;
  logic pop;

  // Only the word-aligned part of the redirect target is used.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // ---------------------------------------------------------------------------
  // Combinational control
  // ---------------------------------------------------------------------------
  assign fifo_empty = (count_q == '0);
  assign not_full   = (count_q < DEPTH_C);

  // Requesting only with free space and nothing outstanding guarantees the
  // response always has a slot to land in.
  assign imem_req_o  = (state_q == ST_IDLE) && not_full && !redirect_i;
  assign imem_addr_o = fetch_pc_q;
  assign grant       = imem_req_o && imem_gnt_i;

  // A response arriving together with a redirect belongs to the old stream.
  assign push = (state_q == ST_WAIT) && imem_rvalid_i && !redirect_i;

  assign instr_valid_o = !fifo_empty;
  assign pop           = instr_valid_o && instr_ready_i;

  // Head is read straight out of the storage registers; no path from rdata.
  assign instr_o = fifo_empty ? 32'h0 : fifo_instr_q[rptr_q];
  assign pc_o    = fifo_empty ? 32'h0 : fifo_pc_q[rptr_q];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;

    // Request/response tracking. grant cannot coincide with redirect_i
    // because imem_req_o is masked by it.
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid_i) begin
          state_d = ST_IDLE;
        end else if (redirect_i) begin
          state_d = ST_DROP;
        end
      end
      ST_DROP: begin
        if (imem_rvalid_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (grant) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_i) begin
      // Flush wins over any push/pop in the same cycle; the latest redirect
      // target always replaces the fetch PC.
      fetch_pc_d = {redirect_pc_i[31:2], 2'b00};
      rptr_d     = '0;
      wptr_d     = '0;
      count_d    = '0;
    end else begin
      if (push) begin
        wptr_d = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= 32'h0;
      rptr_q     <= '0;
      wptr_q     <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      rptr_q     <= rptr_d;
      wptr_q     <= wptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_pc_q[wptr_q]    <= req_pc_q;
      fifo_instr_q[wptr_q] <= imem_rdata_i;
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_push_has_room: assert property (@(posedge clk_i) disable iff (rst_i)
    push |-> not_full);

  a_count_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= DEPTH_C);

  a_ptr_count: assert property (@(posedge clk_i) disable iff (rst_i)
    (wptr_q - rptr_q) == count_q[PTR_W-1:0]);

  a_addr_aligned: assert property (@(posedge clk_i) disable iff (rst_i)
    imem_addr_o[1:0] == 2'b00);
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC  = 32'hFFFF_FFFC;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req, imem_gnt, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic        instr_valid, instr_ready, redirect;
  logic [31:0] instr, pc, redirect_pc;

  logic        w_rst, w_req, w_gnt, w_rvalid, w_valid, w_ready, w_redirect;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_redirect_pc;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i(clk), .rst_i(rst),
    .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(imem_gnt),
    .imem_rvalid_i(imem_rvalid), .imem_rdata_i(imem_rdata),
    .instr_valid_o(instr_valid), .instr_o(instr), .pc_o(pc),
    .instr_ready_i(instr_ready), .redirect_i(redirect), .redirect_pc_i(redirect_pc)
  );

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(WRAP_PC)) u_wrap (
    .clk_i(clk), .rst_i(w_rst),
    .imem_req_o(w_req), .imem_addr_o(w_addr), .imem_gnt_i(w_gnt),
    .imem_rvalid_i(w_rvalid), .imem_rdata_i(w_rdata),
    .instr_valid_o(w_valid), .instr_o(w_instr), .pc_o(w_pc),
    .instr_ready_i(w_ready), .redirect_i(w_redirect), .redirect_pc_i(w_redirect_pc)
  );

  // ---------------- counters / reference model ----------------
  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] exp_q[$];        // {pc, instr} expected in the queue, head first
  logic        model_ok;
  logic        pend, pend_dead; // one request outstanding; dead = flushed
  logic [31:0] pend_pc, model_pc, last_grant_addr;
  int          pend_wait, n_grants;
  int          lat_min, lat_max;
  logic        stray_en;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: predicts outputs from the queue model every cycle, then
  // advances the model with the inputs that the next edge will see.
  task automatic scoreboard();
    logic        exp_req, grant, pop;
    logic [63:0] head;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pend = 1'b0; pend_dead = 1'b0; pend_wait = 0;
        model_pc = RESET_PC;
        model_ok = 1'b1;
      end else if (model_ok) begin
        exp_req = !pend && (exp_q.size() < DEPTH) && !redirect;
        n_checks++;
        if (imem_req !== exp_req) begin
          n_fail++;
          $display("FAIL sb_req: got %b expected %b at %0t", imem_req, exp_req, $time);
        end
        if (exp_req) begin
          n_checks++;
          if (imem_addr !== model_pc) begin
            n_fail++;
            $display("FAIL sb_addr: got %h expected %h at %0t", imem_addr, model_pc, $time);
          end
        end
        n_checks++;
        if (instr_valid !== (exp_q.size() != 0)) begin
          n_fail++;
          $display("FAIL sb_valid: got %b expected %b at %0t", instr_valid, exp_q.size() != 0, $time);
        end
        head = (exp_q.size() != 0) ? exp_q[0] : 64'h0;
        n_checks++;
        if ({pc, instr} !== head) begin
          n_fail++;
          $display("FAIL sb_head: got pc=%h instr=%h expected pc=%h instr=%h at %0t",
                   pc, instr, head[63:32], head[31:0], $time);
        end

        grant = exp_req && imem_gnt;
        pop   = (exp_q.size() != 0) && instr_ready;
        if (grant) begin
          n_grants++;
          last_grant_addr = imem_addr;
        end
        if (pend && !imem_rvalid && pend_wait > 0) pend_wait--;
        if (redirect) begin
          exp_q.delete();
          model_pc = {redirect_pc[31:2], 2'b00};
          if (pend) begin
            if (imem_rvalid) pend = 1'b0;
            else             pend_dead = 1'b1;
          end
        end else begin
          if (pop) void'(exp_q.pop_front());
          if (pend && imem_rvalid) begin
            if (!pend_dead) exp_q.push_back({pend_pc, mem_word(pend_pc)});
            pend = 1'b0;
          end
          if (grant) begin
            pend      = 1'b1;
            pend_dead = 1'b0;
            pend_pc   = model_pc;
            model_pc  = model_pc + 32'd4;
            pend_wait = int'($urandom_range(lat_max - 1, lat_min - 1));
          end
        end
      end
    end
  endtask

  // Memory responder: answers the outstanding request after its latency;
  // optionally throws stray rvalid pulses while nothing is outstanding.
  task automatic responder();
    forever begin
      tick();
      if (pend) begin
        imem_rvalid = (pend_wait == 0);
        imem_rdata  = (pend_wait == 0) ? mem_word(pend_pc) : $urandom;
      end else if (stray_en && $urandom_range(0, 5) == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = $urandom;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    tick();
    rst = 1'b1; imem_gnt = 1'b0; instr_ready = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0; stray_en = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({instr_valid, instr, pc} !== 65'h0) begin
      n_fail++;
      $display("FAIL reset_head: got valid=%b instr=%h pc=%h expected 0/0/0", instr_valid, instr, pc);
    end
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
      n_fail++;
      $display("FAIL reset_req: got req=%b addr=%h expected 1/%h", imem_req, imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    int t_grant, t_valid;
    logic [31:0] got_pc[$];
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_gnt = 1'b1; instr_ready = 1'b1;
    t_grant = -1; t_valid = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && t_grant < 0) t_grant = c;
      if (instr_valid && t_valid < 0) t_valid = c;
      if (instr_valid && instr_ready) begin
        got_pc.push_back(pc);
        n_checks++;
        if (instr !== mem_word(pc)) begin
          n_fail++;
          $display("FAIL seq_instr: got %h expected %h for pc %h", instr, mem_word(pc), pc);
        end
      end
    end
    n_checks++;
    if (t_grant != 0 || t_valid != 2) begin
      n_fail++;
      $display("FAIL seq_latency: got grant@%0d valid@%0d expected 0 and 2", t_grant, t_valid);
    end
    n_checks++;
    if (got_pc.size() < 3) begin
      n_fail++;
      $display("FAIL seq_count: got %0d pops expected at least 3", got_pc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (got_pc[i] !== 32'(4 * i)) begin
          n_fail++;
          $display("FAIL seq_order: pop %0d got pc %h expected %h", i, got_pc[i], 32'(4 * i));
        end
      end
    end
    tick();
  endtask

  task automatic test_backpressure();
    int g0;
    do_reset();
    lat_min = 1; lat_max = 1;
    imem_gnt = 1'b1; instr_ready = 1'b0;
    g0 = n_grants;
    for (int c = 0; c < 15; c++) @(negedge clk);
    tick();
    n_checks++;
    if (n_grants - g0 != DEPTH) begin
      n_fail++;
      $display("FAIL bp_fill: got %0d grants expected %0d", n_grants - g0, DEPTH);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0 || instr_valid !== 1'b1 || pc !== 32'h0) begin
      n_fail++;
      $display("FAIL bp_full: got req=%b valid=%b pc=%h expected 0/1/0", imem_req, instr_valid, pc);
    end
    tick();
    instr_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (pc !== 32'h4 || imem_req !== 1'b1 || imem_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_advance: got pc=%h req=%b addr=%h expected 4/1/10", pc, imem_req, imem_addr);
    end
    for (int c = 0; c < 10; c++) tick();
    n_checks++;
    if (n_grants - g0 != DEPTH + 1 || last_grant_addr !== 32'h10) begin
      n_fail++;
      $display("FAIL bp_refill: got %0d grants last %h expected %0d last 10",
               n_grants - g0, last_grant_addr, DEPTH + 1);
    end
  endtask

  task automatic test_redirect_wait();
    logic found;
    do_reset();
    lat_min = 3; lat_max = 3;
    imem_gnt = 1'b1; instr_ready = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt && imem_addr == 32'h8) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL rw_grant8: got no grant to 8 expected one within 40 cycles");
    end
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (imem_req && imem_gnt) begin
        found = 1'b1;
        n_checks++;
        if (imem_addr !== 32'h100) begin
          n_fail++;
          $display("FAIL rw_newaddr: got %h expected 100", imem_addr);
        end
      end
    end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || pc !== 32'h100) begin
      n_fail++;
      $display("FAIL rw_firstpc: got valid=%b pc=%h expected 1/100", found, pc);
    end
  endtask

  task automatic test_redirect_rvalid();
    logic found;
    do_reset();
    lat_min = 2; lat_max = 2;
    imem_gnt = 1'b1; instr_ready = 1'b1;
    @(negedge clk);               // grant of 0x0 in this cycle
    tick();
    tick();                       // response cycle
    redirect = 1'b1; redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h40 || instr_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rr_restart: got req=%b addr=%h valid=%b expected 1/40/0",
               imem_req, imem_addr, instr_valid);
    end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || pc !== 32'h40) begin
      n_fail++;
      $display("FAIL rr_firstpc: got valid=%b pc=%h expected 1/40", found, pc);
    end
  endtask

  task automatic test_double_redirect();
    logic found;
    do_reset();
    lat_min = 4; lat_max = 4;
    imem_gnt = 1'b1; instr_ready = 1'b1;
    @(negedge clk);               // grant of 0x0
    tick();
    redirect = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_pc = 32'h300;        // second redirect while dropping
    tick();
    redirect = 1'b0;
    @(negedge clk);
    n_checks++;
    if (imem_req !== 1'b0) begin
      n_fail++;
      $display("FAIL dr_drop: got req=%b expected 0 while response pending", imem_req);
    end
    for (int r = 0; r < 2; r++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (imem_req && imem_gnt) found = 1'b1;
      end
      n_checks++;
      if (!found || imem_addr !== 32'h300) begin
        n_fail++;
        $display("FAIL dr_addr%0d: got found=%b addr=%h expected 1/300", r, found, imem_addr);
      end
      if (r == 0) begin
        tick();
        redirect = 1'b1; redirect_pc = 32'h303;
        tick();
        redirect = 1'b0;
      end
    end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (instr_valid) found = 1'b1;
    end
    n_checks++;
    if (!found || pc !== 32'h300 || instr !== mem_word(32'h300)) begin
      n_fail++;
      $display("FAIL dr_head: got pc=%h instr=%h expected 300/%h", pc, instr, mem_word(32'h300));
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_min = 1; lat_max = 4;
    stray_en = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      imem_gnt    = ($urandom_range(0, 9) < 7);
      instr_ready = ($urandom_range(0, 9) < 6);
      redirect    = ($urandom_range(0, 31) == 0);
      rst         = ($urandom_range(0, 399) == 0);
      case ($urandom_range(0, 3))
        0:       redirect_pc = $urandom;
        1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        2:       redirect_pc = 32'($urandom_range(0, 255));
        default: redirect_pc = 32'h100 + 32'($urandom_range(0, 3));
      endcase
      tick();
    end
    rst = 1'b0; redirect = 1'b0; stray_en = 1'b0;
    tick();
  endtask

  task automatic test_wrap();
    tick();
    w_rst = 1'b1; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    tick();
    w_rst = 1'b0; w_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_req !== 1'b1 || w_addr !== WRAP_PC || w_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_reset: got req=%b addr=%h valid=%b expected 1/%h/0", w_req, w_addr, w_valid, WRAP_PC);
    end
    tick();
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h1111_0013;
    @(negedge clk);
    n_checks++;
    if (w_req !== 1'b0) begin
      n_fail++;
      $display("FAIL wrap_wait: got req=%b expected 0", w_req);
    end
    tick();
    w_rvalid = 1'b0; w_gnt = 1'b1;
    @(negedge clk);
    n_checks++;
    if (w_valid !== 1'b1 || w_pc !== WRAP_PC || w_instr !== 32'h1111_0013 ||
        w_req !== 1'b1 || w_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_next: got valid=%b pc=%h instr=%h req=%b addr=%h expected 1/%h/11110013/1/0",
               w_valid, w_pc, w_instr, w_req, w_addr, WRAP_PC);
    end
    tick();
    w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = 32'h2222_0013;
    tick();
    w_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_valid !== 1'b1 || w_pc !== WRAP_PC || w_addr !== 32'h4) begin
      n_fail++;
      $display("FAIL wrap_two: got valid=%b pc=%h addr=%h expected 1/%h/4", w_valid, w_pc, w_addr, WRAP_PC);
    end
    tick();
    w_rst = 1'b1;
    tick();
    w_rst = 1'b0; w_rvalid = 1'b1; w_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_checks++;
    if (w_valid !== 1'b0 || w_pc !== 32'h0 || w_instr !== 32'h0 ||
        w_req !== 1'b1 || w_addr !== WRAP_PC) begin
      n_fail++;
      $display("FAIL wrap_midreset: got valid=%b pc=%h instr=%h req=%b addr=%h expected 0/0/0/1/%h",
               w_valid, w_pc, w_instr, w_req, w_addr, WRAP_PC);
    end
    tick();
    w_rvalid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (w_valid !== 1'b0 || w_addr !== WRAP_PC) begin
      n_fail++;
      $display("FAIL wrap_stray: got valid=%b addr=%h expected 0/%h", w_valid, w_addr, WRAP_PC);
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b1; imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    w_rst = 1'b1; w_gnt = 1'b0; w_rvalid = 1'b0; w_rdata = 32'h0;
    w_ready = 1'b0; w_redirect = 1'b0; w_redirect_pc = 32'h0;
    model_ok = 1'b0; pend = 1'b0; pend_dead = 1'b0; pend_pc = 32'h0;
    pend_wait = 0; model_pc = RESET_PC; last_grant_addr = 32'h0; n_grants = 0;
    lat_min = 1; lat_max = 1; stray_en = 1'b0;
    fork
      scoreboard();
      responder();
    join_none
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_double_redirect();
    test_random();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
